// File: rtl/axis_frame_arbiter_pkg.sv
// Shared types for the two-port AXI-Stream frame arbiter.
package axis_frame_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry FIFO between the arbiter and the shared core; full blocks push, empty blocks pop.
module axis_skid_buffer #(
  parameter int WIDTH = 10
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             push, pop;

  assign in_ready_o  = (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage is cleared too so the output data reads zero while in reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/axis_frame_arbiter.sv
// Packet-granular round-robin arbiter merging two AXI-Stream sources onto one core.
//   state  | meaning
//   IDLE   | no grant; pick a port, accept nothing this cycle
//   GRANT0 | port 0 owns the output until its last beat is accepted
//   GRANT1 | port 1 owns the output until its last beat is accepted
module axis_frame_arbiter
  import axis_frame_arbiter_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [DATA_BITS-1:0] s0_data_i,
  input  logic                 s0_valid_i,
  output logic                 s0_ready_o,
  input  logic                 s0_last_i,
  input  logic [DATA_BITS-1:0] s1_data_i,
  input  logic                 s1_valid_i,
  output logic                 s1_ready_o,
  input  logic                 s1_last_i,
  output logic [DATA_BITS-1:0] m_data_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic                 m_last_o,
  output logic                 m_id_o,
  output logic                 busy_o,
  output logic [CNT_BITS-1:0]  pkt_cnt0_o,
  output logic [CNT_BITS-1:0]  pkt_cnt1_o
);

  localparam int BUF_W = DATA_BITS + 2;

  arb_state_e          state_q, state_d;
  logic                prio_q, prio_d;
  logic [CNT_BITS-1:0] cnt0_q, cnt0_d;
  logic [CNT_BITS-1:0] cnt1_q, cnt1_d;

  logic                buf_ready;
  logic                buf_valid;
  logic                push;
  logic [BUF_W-1:0]    push_data;
  logic [BUF_W-1:0]    buf_out;

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    s0_ready_o = 1'b0;
    s1_ready_o = 1'b0;
    push       = 1'b0;
    push_data  = '0;
    case (state_q)
      IDLE: begin
        if (s0_valid_i && s1_valid_i) begin
          state_d = (prio_q == PORT1) ? GRANT1 : GRANT0;
        end else if (s0_valid_i) begin
          state_d = GRANT0;
        end else if (s1_valid_i) begin
          state_d = GRANT1;
        end
      end
      GRANT0: begin
        s0_ready_o = buf_ready;
        push       = s0_valid_i && buf_ready;
        push_data  = {s0_data_i, s0_last_i, PORT0};
        if (push && s0_last_i) begin
          state_d = IDLE;
          prio_d  = PORT1;
          cnt0_d  = cnt0_q + CNT_BITS'(1);
        end
      end
      GRANT1: begin
        s1_ready_o = buf_ready;
        push       = s1_valid_i && buf_ready;
        push_data  = {s1_data_i, s1_last_i, PORT1};
        if (push && s1_last_i) begin
          state_d = IDLE;
          prio_d  = PORT0;
          cnt1_d  = cnt1_q + CNT_BITS'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      prio_q  <= PORT0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  axis_skid_buffer #(
    .WIDTH(BUF_W)
  ) u_buf (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .in_data_i   (push_data),
    .in_valid_i  (push),
    .in_ready_o  (buf_ready),
    .out_data_o  (buf_out),
    .out_valid_o (buf_valid),
    .out_ready_i (m_ready_i)
  );

  assign m_data_o   = buf_out[BUF_W-1:2];
  assign m_last_o   = buf_out[1];
  assign m_id_o     = buf_out[0];
  assign m_valid_o  = buf_valid;
  assign busy_o     = (state_q != IDLE) || buf_valid;
  assign pkt_cnt0_o = cnt0_q;
  assign pkt_cnt1_o = cnt1_q;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Randomised bench for axis_frame_arbiter with a queue-based reference model.
module tb_axis_frame_arbiter;

  localparam int DB = 8;
  localparam int CB = 8;

  logic          clk_i  = 1'b0;
  logic          rstn_i = 1'b0;
  logic [DB-1:0] s0_data_i = '0, s1_data_i = '0;
  logic          s0_valid_i = 1'b0, s1_valid_i = 1'b0;
  logic          s0_last_i = 1'b0, s1_last_i = 1'b0;
  logic          s0_ready_o, s1_ready_o;
  logic [DB-1:0] m_data_o;
  logic          m_valid_o, m_last_o, m_id_o, busy_o;
  logic          m_ready_i = 1'b0;
  logic [CB-1:0] pkt_cnt0_o, pkt_cnt1_o;

  always #5 clk_i = ~clk_i;

  axis_frame_arbiter #(.DATA_BITS(DB), .CNT_BITS(CB)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .s0_data_i(s0_data_i), .s0_valid_i(s0_valid_i), .s0_ready_o(s0_ready_o), .s0_last_i(s0_last_i),
    .s1_data_i(s1_data_i), .s1_valid_i(s1_valid_i), .s1_ready_o(s1_ready_o), .s1_last_i(s1_last_i),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_last_o(m_last_o),
    .m_id_o(m_id_o), .busy_o(busy_o), .pkt_cnt0_o(pkt_cnt0_o), .pkt_cnt1_o(pkt_cnt1_o)
  );

  typedef struct {
    logic [DB-1:0] d;
    logic          l;
    logic          id;
  } beat_t;

  beat_t src_q[2][$];
  beat_t ref_q[2][$];
  beat_t mfifo[$];
  beat_t log_q[$];

  int   owner;
  int   ptr;
  int   mcnt[2];
  int   acc_total[2];
  logic vh[2];
  int   pv, pr;
  logic out_mid;
  logic out_id_prev;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic enq(input int port, input int len, input logic [DB-1:0] base, input bit rnd);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d  = rnd ? DB'($urandom) : DB'(base + DB'(i));
      b.l  = (i == len - 1);
      b.id = port[0];
      src_q[port].push_back(b);
      ref_q[port].push_back(b);
    end
  endtask

  task automatic check_outputs();
    chk("s0_ready", s0_ready_o, (owner == 0) && (mfifo.size() < 2));
    chk("s1_ready", s1_ready_o, (owner == 1) && (mfifo.size() < 2));
    chk("m_valid", m_valid_o, mfifo.size() != 0);
    if (mfifo.size() != 0) begin
      chk("m_data", m_data_o, mfifo[0].d);
      chk("m_last", m_last_o, mfifo[0].l);
      chk("m_id", m_id_o, mfifo[0].id);
    end
    chk("busy", busy_o, (owner >= 0) || (mfifo.size() != 0));
    chk("pkt_cnt0", pkt_cnt0_o, mcnt[0]);
    chk("pkt_cnt1", pkt_cnt1_o, mcnt[1]);
  endtask

  task automatic observe_pop();
    beat_t b;
    if ($isunknown({m_id_o, m_data_o, m_last_o})) begin
      chk("out_known", 1, 0);
      return;
    end
    if (ref_q[m_id_o].size() == 0) begin
      chk("out_unexpected_beat", 1, 0);
      return;
    end
    b = ref_q[m_id_o].pop_front();
    chk("stream_data", m_data_o, b.d);
    chk("stream_last", m_last_o, b.l);
    if (out_mid) chk("no_interleave", m_id_o, out_id_prev);
    out_mid     = !m_last_o;
    out_id_prev = m_id_o;
    b.id = m_id_o;
    log_q.push_back(b);
  endtask

  task automatic step();
    logic  v[2];
    beat_t cur[2];
    logic  r[2];
    int    ap;
    @(negedge clk_i);
    check_outputs();
    for (int p = 0; p < 2; p++) begin
      if (!vh[p] && src_q[p].size() > 0 && ($urandom % 100) < pv) vh[p] = 1'b1;
      v[p] = vh[p];
      if (vh[p]) cur[p] = src_q[p][0];
      else begin
        cur[p].d = DB'($urandom);
        cur[p].l = $urandom % 2;
      end
      cur[p].id = p[0];
    end
    s0_valid_i = v[0]; s0_data_i = cur[0].d; s0_last_i = cur[0].l;
    s1_valid_i = v[1]; s1_data_i = cur[1].d; s1_last_i = cur[1].l;
    m_ready_i  = ($urandom % 100) < pr;
    if (m_valid_o && m_ready_i) observe_pop();
    // Reference: grants are whole packets, decision cycle accepts nothing, buffer holds two.
    for (int p = 0; p < 2; p++) r[p] = (owner == p) && (mfifo.size() < 2);
    ap = -1;
    if (owner >= 0 && v[owner] && r[owner]) ap = owner;
    if (mfifo.size() > 0 && m_ready_i) void'(mfifo.pop_front());
    if (ap >= 0) begin
      mfifo.push_back(src_q[ap].pop_front());
      vh[ap] = 1'b0;
      acc_total[ap]++;
    end
    if (owner < 0) begin
      if (v[0] && v[1]) owner = ptr;
      else if (v[0])    owner = 0;
      else if (v[1])    owner = 1;
    end else if (ap >= 0 && cur[ap].l) begin
      mcnt[ap] = (mcnt[ap] + 1) % (1 << CB);
      ptr      = 1 - ap;
      owner    = -1;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((src_q[0].size() != 0 || src_q[1].size() != 0 || mfifo.size() != 0 ||
            owner >= 0 || vh[0] || vh[1]) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) chk("drain_timeout", 1, 0);
    step();
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rstn_i = 1'b0;
    #1;
    chk("rst_s0_ready", s0_ready_o, 0);
    chk("rst_s1_ready", s1_ready_o, 0);
    chk("rst_m_valid", m_valid_o, 0);
    chk("rst_m_last", m_last_o, 0);
    chk("rst_m_id", m_id_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_m_data", m_data_o, 0);
    chk("rst_cnt0", pkt_cnt0_o, 0);
    chk("rst_cnt1", pkt_cnt1_o, 0);
    owner = -1; ptr = 0; out_mid = 1'b0; out_id_prev = 1'b0;
    mfifo.delete();
    for (int p = 0; p < 2; p++) begin
      src_q[p].delete(); ref_q[p].delete();
      mcnt[p] = 0; acc_total[p] = 0; vh[p] = 1'b0;
    end
    s0_valid_i = 1'b0; s1_valid_i = 1'b0; s0_last_i = 1'b0; s1_last_i = 1'b0;
    m_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
  endtask

  initial begin
    int exp_d[6];
    int exp_id[6];
    int n;

    pv = 100; pr = 100;
    do_reset();

    // Single 4-beat packet on port 0, back to back.
    enq(0, 4, 8'h10, 0);
    log_q.delete();
    drain(50);
    chk("p38_len", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      chk("p38_data", log_q[i].d, 32'h10 + i);
      chk("p38_last", log_q[i].l, (i == 3));
      chk("p38_id", log_q[i].id, 0);
    end
    chk("p38_cnt0", pkt_cnt0_o, 1);

    // Contention from reset: port 0 first, then port 1, then port 0 again.
    do_reset();
    enq(0, 2, 8'h20, 0);
    enq(1, 2, 8'h30, 0);
    log_q.delete();
    drain(50);
    enq(0, 2, 8'h40, 0);
    drain(50);
    exp_d  = '{32'h20, 32'h21, 32'h30, 32'h31, 32'h40, 32'h41};
    exp_id = '{0, 0, 1, 1, 0, 0};
    chk("p39_len", log_q.size(), 6);
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      chk("p39_data", log_q[i].d, exp_d[i]);
      chk("p39_id", log_q[i].id, exp_id[i]);
    end

    // Output stall mid-packet: buffer fills, source throttled, head held.
    do_reset();
    enq(0, 4, 8'h50, 0);
    log_q.delete();
    step();
    step();
    pr = 0;
    repeat (5) step();
    chk("p40_s0_ready", s0_ready_o, 0);
    chk("p40_m_valid", m_valid_o, 1);
    chk("p40_m_data", m_data_o, 32'h50);
    chk("p40_busy", busy_o, 1);
    pr = 100;
    drain(50);
    chk("p40_len", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) chk("p40_data", log_q[i].d, 32'h50 + i);

    // Counter wrap with 8-bit counters.
    do_reset();
    for (int i = 0; i < 255; i++) enq(1, 1, DB'(i), 0);
    drain(2000);
    chk("p41_cnt1_255", pkt_cnt1_o, 255);
    enq(1, 1, 8'hAA, 0);
    drain(20);
    chk("p41_cnt1_0", pkt_cnt1_o, 0);
    enq(1, 1, 8'hAB, 0);
    drain(20);
    chk("p41_cnt1_1", pkt_cnt1_o, 1);

    // Reset in the middle of a packet.
    do_reset();
    enq(0, 4, 8'h60, 0);
    n = 0;
    while (acc_total[0] < 2 && n < 20) begin
      step();
      n++;
    end
    chk("p42_reached_beat2", acc_total[0] >= 2, 1);
    do_reset();
    enq(0, 4, 8'h70, 0);
    log_q.delete();
    drain(50);
    chk("p42_len", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) chk("p42_data", log_q[i].d, 32'h70 + i);
    chk("p42_cnt0", pkt_cnt0_o, 1);

    // Random traffic: 500 packets per port, random lengths and handshakes.
    do_reset();
    pv = 60; pr = 60;
    for (int k = 0; k < 500; k++) begin
      enq(0, 1 + ($urandom % 4), 8'h00, 1);
      enq(1, 1 + ($urandom % 4), 8'h00, 1);
    end
    drain(40000);
    chk("rnd_ref0_left", ref_q[0].size(), 0);
    chk("rnd_ref1_left", ref_q[1].size(), 0);
    chk("rnd_cnt0", pkt_cnt0_o, 500 % 256);
    chk("rnd_cnt1", pkt_cnt1_o, 500 % 256);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
